// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard scheduler.
//   state_t    : scheduler FSM states (RUN, HOLD, KILL)
//   sb_wa_t    : scoreboard write-address field. It is wide enough for any
//                RA_W up to RA_W_MAX; narrower addresses are zero-extended.
//   sb_entry_t : one scoreboard slot {v, wa}
//   ZERO_REG   : register $0, which is never a hazard source
// ---------------------------------------------------------------------------
package hazard_pkg;

    localparam int unsigned RA_W_MAX = 8;

    typedef logic [RA_W_MAX-1:0] sb_wa_t;

    localparam sb_wa_t ZERO_REG = '0;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        KILL = 2'd2
    } state_t;

    typedef struct packed {
        logic   v;
        sb_wa_t wa;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Shift register of pending register-file writes. Entry 0 is EX, and higher
// entries are later stages. Each source address is compared against the
// entries that can still be unreadable from the register file.
// Ports:
//   clk, rst (async, active-low)
//   ld_v, ld_wa    : write that leaves ID this cycle (ld_v=0 for bubbles)
//   rs, rt         : source addresses of the instruction in ID
//   use_rs, use_rt : the source is actually read
//   hit_rs, hit_rt : source collides with a pending write
// RA_W must not exceed hazard_pkg::RA_W_MAX.
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned RA_W           = 5,
    parameter int unsigned SB_DEPTH       = 3,
    parameter int unsigned RF_WRITE_FIRST = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_v,
    input  logic [RA_W-1:0] ld_wa,
    input  logic [RA_W-1:0] rs,
    input  logic [RA_W-1:0] rt,
    input  logic            use_rs,
    input  logic            use_rt,
    output logic            hit_rs,
    output logic            hit_rt
);

    // With a write-first register file, the WB slot already reads back the
    // new value, so only the stages ahead of it can cause a hazard.
    localparam int unsigned CHK = (RF_WRITE_FIRST != 0) ? SB_DEPTH - 1 : SB_DEPTH;

    sb_entry_t entry_q [SB_DEPTH];
    sb_entry_t entry_d [SB_DEPTH];

    sb_wa_t rs_x;
    sb_wa_t rt_x;
    logic [SB_DEPTH-1:0] match_rs;
    logic [SB_DEPTH-1:0] match_rt;

    assign rs_x = sb_wa_t'(rs);
    assign rt_x = sb_wa_t'(rt);

    always_comb begin
        entry_d[0].v  = ld_v;
        entry_d[0].wa = sb_wa_t'(ld_wa);
        for (int i = 1; i < int'(SB_DEPTH); i++) begin
            entry_d[i] = entry_q[i-1];
        end
    end

    generate
        for (genvar gi = 0; gi < int'(SB_DEPTH); gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    entry_q[gi] <= '0;
                end else begin
                    entry_q[gi] <= entry_d[gi];
                end
            end

            if (gi < int'(CHK)) begin : g_chk
                assign match_rs[gi] = entry_q[gi].v && (entry_q[gi].wa == rs_x);
                assign match_rt[gi] = entry_q[gi].v && (entry_q[gi].wa == rt_x);
            end else begin : g_nochk
                assign match_rs[gi] = 1'b0;
                assign match_rt[gi] = 1'b0;
            end
        end
    endgenerate

    assign hit_rs = use_rs && (rs_x != ZERO_REG) && (|match_rs);
    assign hit_rt = use_rt && (rt_x != ZERO_REG) && (|match_rt);

endmodule

// File: rtl/hazard_sched.sv
// ---------------------------------------------------------------------------
// hazard_sched
// Interlock and flush control for a 5-stage MIPS pipeline without forwarding.
// Ports:
//   clk, rst (async, active-low)
//   id_*        : decoded instruction currently in ID
//   ex_br_taken : taken branch resolved in EX
//   stall       : hold PC and IF/ID
//   bubble_idex : load a NOP into ID/EX
//   flush_ifid  : turn IF/ID into a NOP
//   busy_hilo   : a multiply has not yet produced HI/LO
//   stall_cnt, flush_cnt : saturating event counters, present only when
//                          HAZARD_PERF_EN is defined
// Outputs are combinational from registered state and the ID/EX inputs. They
// are forced low while rst is asserted.
// ---------------------------------------------------------------------------
module hazard_sched
    import hazard_pkg::*;
#(
    parameter int unsigned RA_W           = 5,
    parameter int unsigned SB_DEPTH       = 3,
    parameter int unsigned RF_WRITE_FIRST = 1,
    parameter int unsigned MUL_LAT        = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic [RA_W-1:0] id_wa,
    input  logic            id_we,
    input  logic            id_mul,
    input  logic            id_mfhilo,
    input  logic            id_jump,
    input  logic            id_jr,
    input  logic            ex_br_taken,
    output logic            stall,
    output logic            bubble_idex,
    output logic            flush_ifid,
    output logic            busy_hilo
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hilo_cnt_q, hilo_cnt_d;

    logic id_live;
    logic hit_rs, hit_rt;
    logic busy;
    logic stall_int;
    logic bubble_int;
    logic flush_int;
    logic mul_issue;

    // In KILL, ID holds the wrong-path instruction fetched behind the branch.
    assign id_live = id_valid && (state_q != KILL);
    assign busy    = (hilo_cnt_q != '0);

    hazard_scoreboard #(
        .RA_W           (RA_W),
        .SB_DEPTH       (SB_DEPTH),
        .RF_WRITE_FIRST (RF_WRITE_FIRST)
    ) u_sb (
        .clk    (clk),
        .rst    (rst),
        .ld_v   (id_live && id_we && !bubble_int),
        .ld_wa  (id_wa),
        .rs     (id_rs),
        .rt     (id_rt),
        .use_rs (id_use_rs),
        .use_rt (id_use_rt),
        .hit_rs (hit_rs),
        .hit_rt (hit_rt)
    );

    // A taken branch overrides every interlock. The stalled instruction is on
    // the wrong path anyway.
    assign stall_int  = id_live && !ex_br_taken &&
                        (hit_rs || hit_rt || ((id_mfhilo || id_mul) && busy));
    assign bubble_int = stall_int || ex_br_taken;
    // A jr waiting on rs must not redirect until its operand is readable.
    assign flush_int  = ex_br_taken || (id_live && !stall_int && (id_jump || id_jr));
    assign mul_issue  = id_live && id_mul && !stall_int && !ex_br_taken;

    assign stall       = rst && stall_int;
    assign bubble_idex = rst && bubble_int;
    assign flush_ifid  = rst && flush_int;
    assign busy_hilo   = busy;

    always_comb begin
        hilo_cnt_d = hilo_cnt_q;
        if (mul_issue) begin
            hilo_cnt_d = CNT_W'(MUL_LAT);
        end else if (busy) begin
            hilo_cnt_d = hilo_cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     state_d = ex_br_taken ? KILL : (stall_int ? HOLD : RUN);
            HOLD:    state_d = ex_br_taken ? KILL : (stall_int ? HOLD : RUN);
            KILL:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            hilo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hilo_cnt_q <= hilo_cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_int && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush_int && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// ---------------------------------------------------------------------------
// tb_hazard_sched
// Directed scenarios followed by randomized instruction streams. The expected
// outputs come from a reference model that remembers which register each past
// cycle wrote and when the last multiply issued. It prints one line per cycle.
// Counter ports are connected when HAZARD_PERF_EN is defined.
// ---------------------------------------------------------------------------
module tb_hazard_sched;

    localparam int RA_W           = 5;
    localparam int SB_DEPTH       = 3;
    localparam int RF_WRITE_FIRST = 1;
    localparam int MUL_LAT        = 2;
    localparam int CHK            = (RF_WRITE_FIRST != 0) ? SB_DEPTH - 1 : SB_DEPTH;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            id_valid, id_use_rs, id_use_rt, id_we, id_mul, id_mfhilo, id_jump, id_jr;
    logic [RA_W-1:0] id_rs, id_rt, id_wa;
    logic            ex_br_taken;
    logic            stall, bubble_idex, flush_ifid, busy_hilo;
`ifdef HAZARD_PERF_EN
    logic [31:0]     stall_cnt, flush_cnt;
`endif

    hazard_sched #(
        .RA_W           (RA_W),
        .SB_DEPTH       (SB_DEPTH),
        .RF_WRITE_FIRST (RF_WRITE_FIRST),
        .MUL_LAT        (MUL_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_wa       (id_wa),
        .id_we       (id_we),
        .id_mul      (id_mul),
        .id_mfhilo   (id_mfhilo),
        .id_jump     (id_jump),
        .id_jr       (id_jr),
        .ex_br_taken (ex_br_taken),
        .stall       (stall),
        .bubble_idex (bubble_idex),
        .flush_ifid  (flush_ifid),
        .busy_hilo   (busy_hilo)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // ---------------- reference model state ----------------
    int   hist[$];           // hist[k] = register written by the instruction that left ID k+1 cycles ago, -1 if none
    int   last_mult = -100;  // cycle in which the last mult left ID
    logic prev_br   = 1'b0;  // a taken branch was seen last cycle (ID is wrong-path now)

    logic e_stall, e_bubble, e_flush, e_busy;
    logic obs_stall, obs_bubble, obs_flush, obs_busy;

    function automatic logic pending(input int a);
        for (int k = 0; k < CHK && k < hist.size(); k++) begin
            if (hist[k] == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_expect();
        logic live, raw;
        live     = rst && id_valid && !prev_br;
        raw      = (id_use_rs && id_rs != 0 && pending(int'(id_rs))) ||
                   (id_use_rt && id_rt != 0 && pending(int'(id_rt)));
        e_busy   = rst && (cyc - last_mult >= 1) && (cyc - last_mult <= MUL_LAT);
        e_stall  = live && !ex_br_taken && (raw || ((id_mfhilo || id_mul) && e_busy));
        e_bubble = rst && (e_stall || ex_br_taken);
        e_flush  = rst && (ex_br_taken || (live && !e_stall && (id_jump || id_jr)));
    endtask

    task automatic model_update();
        logic live;
        if (!rst) begin
            hist.delete();
            last_mult = -100;
            prev_br   = 1'b0;
        end else begin
            live = id_valid && !prev_br;
            if (live && id_we && !e_bubble) hist.push_front(int'(id_wa));
            else                            hist.push_front(-1);
            if (hist.size() > SB_DEPTH) void'(hist.pop_back());
            if (live && id_mul && !e_stall && !ex_br_taken) last_mult = cyc;
            prev_br = ex_br_taken;
        end
        cyc++;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic o, input logic e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, o, e);
        end
    endtask

    task automatic chk_int(input string tag, input int o, input int e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, o, e);
        end
    endtask

    // One clock: compare against the model mid-cycle, then advance the model.
    task automatic tick();
        @(negedge clk);
        model_expect();
        obs_stall  = stall;
        obs_bubble = bubble_idex;
        obs_flush  = flush_ifid;
        obs_busy   = busy_hilo;
        chk("stall",       obs_stall,  e_stall);
        chk("bubble_idex", obs_bubble, e_bubble);
        chk("flush_ifid",  obs_flush,  e_flush);
        chk("busy_hilo",   obs_busy,   e_busy);
        $display("cyc=%0d rst=%0b v=%0b rs=%0d/%0b rt=%0d/%0b wa=%0d/%0b mul=%0b mfh=%0b j=%0b jr=%0b br=%0b -> stall=%0b bub=%0b fl=%0b busy=%0b",
                 cyc, rst, id_valid, id_rs, id_use_rs, id_rt, id_use_rt, id_wa, id_we,
                 id_mul, id_mfhilo, id_jump, id_jr, ex_br_taken,
                 obs_stall, obs_bubble, obs_flush, obs_busy);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_id(input logic v, input int rs, input int rt, input logic urs, input logic urt,
                          input int wa, input logic we, input logic mul, input logic mfh,
                          input logic jmp, input logic jr);
        id_valid  = v;
        id_rs     = RA_W'(rs);
        id_rt     = RA_W'(rt);
        id_use_rs = urs;
        id_use_rt = urt;
        id_wa     = RA_W'(wa);
        id_we     = we;
        id_mul    = mul;
        id_mfhilo = mfh;
        id_jump   = jmp;
        id_jr     = jr;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        nop();
        ex_br_taken = 1'b0;
        repeat (3) tick();
    endtask

    // Keep ticking while the current ID instruction stalls (bounded).
    task automatic count_stalls(output int ns, output int nf);
        ns = 0;
        nf = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (obs_flush) nf++;
            if (obs_stall) ns++;
            else break;
        end
    endtask

    int ns, nf, nbusy;
    logic [RA_W-1:0] cur_rs, cur_rt, cur_wa;
    logic cur_v, cur_urs, cur_urt, cur_we, cur_mul, cur_mfh, cur_j, cur_jr;

    initial begin
        nop();
        ex_br_taken = 1'b0;

        // Reset: outputs must stay low even with a branch and jump present.
        rst = 1'b0;
        set_id(1, 0, 0, 0, 0, 31, 1, 0, 0, 1, 0);
        ex_br_taken = 1'b1;
        tick();
        chk("reset_flush", obs_flush, 1'b0);
        chk("reset_bubble", obs_bubble, 1'b0);
        nop();
        ex_br_taken = 1'b0;
        tick();
`ifdef HAZARD_PERF_EN
        chk_int("reset_stall_cnt", int'(stall_cnt), 0);
        chk_int("reset_flush_cnt", int'(flush_cnt), 0);
`endif
        rst = 1'b1;
        tick();

        // addu $3 then addu $4,$3,$5: two stall cycles.
        set_id(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0);
        tick();
        set_id(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 0);
        count_stalls(ns, nf);
        chk_int("raw_stall_cycles", ns, 2);
        drain();

        // Write to $0 then read $0: never stalls.
        set_id(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tick();
        set_id(1, 0, 0, 1, 1, 6, 1, 0, 0, 0, 0);
        count_stalls(ns, nf);
        chk_int("zero_reg_stalls", ns, 0);
        drain();

        // mult then mfhi, then mult back-to-back.
        set_id(1, 1, 2, 1, 1, 0, 0, 1, 0, 0, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 8, 1, 0, 1, 0, 0);
        nbusy = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (obs_busy) nbusy++;
            if (!obs_stall) break;
        end
        chk_int("mfhi_busy_cycles", nbusy, 2);
        drain();
        set_id(1, 1, 2, 1, 1, 0, 0, 1, 0, 0, 0);
        tick();
        count_stalls(ns, nf);
        chk_int("mult_mult_stalls", ns, 2);
        drain();

        // Taken branch while ID has a RAW hit.
        set_id(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0);
        tick();
        set_id(1, 3, 0, 1, 0, 4, 1, 0, 0, 0, 0);
        ex_br_taken = 1'b1;
        tick();
        chk("br_raw_stall", obs_stall, 1'b0);
        chk("br_raw_flush", obs_flush, 1'b1);
        chk("br_raw_bubble", obs_bubble, 1'b1);
        ex_br_taken = 1'b0;
        set_id(1, 3, 0, 1, 0, 7, 1, 0, 0, 1, 0);
        tick();
        chk("kill_stall", obs_stall, 1'b0);
        chk("kill_flush", obs_flush, 1'b0);
        set_id(1, 4, 7, 1, 1, 9, 1, 0, 0, 0, 0);
        tick();
        chk("killed_write_no_stall", obs_stall, 1'b0);
        drain();

        // jal then jr $31.
        set_id(1, 0, 0, 0, 0, 31, 1, 0, 0, 1, 0);
        tick();
        chk("jal_flush", obs_flush, 1'b1);
        set_id(1, 31, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        count_stalls(ns, nf);
        chk_int("jr_stalls", ns, 2);
        chk_int("jr_flushes", nf, 1);
        drain();

        // Reset during HOLD.
        set_id(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0);
        tick();
        set_id(1, 3, 0, 1, 0, 4, 1, 0, 0, 0, 0);
        tick();
        tick();
        chk("hold_stall", obs_stall, 1'b1);
        rst = 1'b0;
        #1;
        chk("rst_stall_now", stall, 1'b0);
        chk("rst_bubble_now", bubble_idex, 1'b0);
        chk("rst_flush_now", flush_ifid, 1'b0);
        chk("rst_busy_now", busy_hilo, 1'b0);
        tick();
`ifdef HAZARD_PERF_EN
        chk_int("rst_stall_cnt", int'(stall_cnt), 0);
        chk_int("rst_flush_cnt", int'(flush_cnt), 0);
`endif
        rst = 1'b1;
        tick();
        chk("post_rst_no_stall", obs_stall, 1'b0);
        drain();

        // Randomized stream: a stalled instruction is held in ID, and no
        // two taken branches arrive back-to-back.
        cur_v = 0; cur_rs = 0; cur_rt = 0; cur_urs = 0; cur_urt = 0; cur_wa = 0;
        cur_we = 0; cur_mul = 0; cur_mfh = 0; cur_j = 0; cur_jr = 0;
        for (int n = 0; n < 250; n++) begin
            if (!obs_stall || ex_br_taken) begin
                cur_v   = ($urandom_range(0, 9) != 0);
                cur_rs  = RA_W'($urandom_range(0, 3));
                cur_rt  = RA_W'($urandom_range(0, 3));
                cur_urs = ($urandom_range(0, 3) != 0);
                cur_urt = ($urandom_range(0, 1) != 0);
                cur_wa  = RA_W'($urandom_range(0, 3));
                cur_we  = ($urandom_range(0, 9) < 7);
                cur_mul = ($urandom_range(0, 9) == 0);
                cur_mfh = ($urandom_range(0, 9) == 0);
                cur_j   = ($urandom_range(0, 19) == 0);
                cur_jr  = ($urandom_range(0, 19) == 0);
            end
            set_id(cur_v, int'(cur_rs), int'(cur_rt), cur_urs, cur_urt, int'(cur_wa),
                   cur_we, cur_mul, cur_mfh, cur_j, cur_jr);
            ex_br_taken = !ex_br_taken && ($urandom_range(0, 99) < 8);
            tick();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
